// File: rtl/event_trace_packer.sv
// event_trace_packer: packs per-channel edge pulses into timestamped words,
// buffers them in a FIFO and drives them out as an AXI4-Stream master.
// Word layout (MSB..LSB): {rise_vec, fall_vec, timestamp}.
// Optional build macro TRACE_OVERFLOW_MARKER_EN: after a drop, insert one
// marker word {all ones, all ones, timestamp} at the first idle, non-full slot.
module event_trace_packer #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned TS_W       = 32,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned DROP_W     = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          enable,
  input  logic [NUM_CH-1:0]             rise_pulse,
  input  logic [NUM_CH-1:0]             fall_pulse,
  output logic [2*NUM_CH+TS_W-1:0]      m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [DROP_W-1:0]             dropped_count,
  output logic                          overflow
);

  localparam int unsigned DATA_W = 2 * NUM_CH + TS_W;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;

  // Reset synchronizer: asserts asynchronously, releases on the clock.
  logic r_rst_meta;
  logic r_rst_n;

  // Free-running timestamp.
  logic [TS_W-1:0] r_ts;

  // Capture stage: one word per event cycle.
  logic              r_ev_valid;
  logic [NUM_CH-1:0] r_ev_rise;
  logic [NUM_CH-1:0] r_ev_fall;
  logic [TS_W-1:0]   r_ev_ts;

  // Buffer storage; the output register holds the head word.
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic [DATA_W-1:0] r_tdata;
  logic              r_tvalid;
  logic [DROP_W-1:0] r_dropped;
  logic              r_overflow;
`ifdef TRACE_OVERFLOW_MARKER_EN
  logic              r_mark_pend;
`endif

  logic              w_event;
  logic              w_full;
  logic              w_pop;
  logic              w_load;
  logic [LVL_W-1:0]  w_mem_cnt;
  logic              w_mem_empty;
  logic              w_mark_ins;
  logic              w_wr_req;
  logic [DATA_W-1:0] w_wr_data;
  logic              w_push;
  logic              w_drop;
  logic              w_bypass;
  logic              w_mem_wr;
  logic              w_mem_rd;

  // Two-flop reset synchronizer for clean deassertion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rst_meta <= 1'b0;
      r_rst_n    <= 1'b0;
    end else begin
      r_rst_meta <= 1'b1;
      r_rst_n    <= r_rst_meta;
    end
  end

  // Timestamp counter, wraps silently.
  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
    end
  end

  assign w_event = enable & ((|rise_pulse) | (|fall_pulse));

  // Capture pulses with the pre-increment timestamp.
  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_ev_valid <= 1'b0;
      r_ev_rise  <= '0;
      r_ev_fall  <= '0;
      r_ev_ts    <= '0;
    end else begin
      r_ev_valid <= w_event;
      if (w_event) begin
        r_ev_rise <= rise_pulse;
        r_ev_fall <= fall_pulse;
        r_ev_ts   <= r_ts;
      end
    end
  end

  // Write/pop decisions; a full buffer still accepts when it pops this cycle.
  always_comb begin
    w_full      = (r_level == LVL_W'(FIFO_DEPTH));
    w_pop       = r_tvalid & m_axis_tready;
    w_load      = ~r_tvalid | w_pop;
    w_mem_cnt   = r_level - LVL_W'(r_tvalid);
    w_mem_empty = (w_mem_cnt == '0);
`ifdef TRACE_OVERFLOW_MARKER_EN
    w_mark_ins  = r_mark_pend & ~r_ev_valid & ~w_full;
`else
    w_mark_ins  = 1'b0;
`endif
    w_wr_req    = r_ev_valid | w_mark_ins;
    if (r_ev_valid) begin
      w_wr_data = {r_ev_rise, r_ev_fall, r_ev_ts};
    end else begin
      w_wr_data = {{NUM_CH{1'b1}}, {NUM_CH{1'b1}}, r_ts};
    end
    w_push      = w_wr_req & (~w_full | w_pop);
    w_drop      = r_ev_valid & w_full & ~w_pop;
    w_bypass    = w_push & w_load & w_mem_empty;
    w_mem_wr    = w_push & ~w_bypass;
    w_mem_rd    = w_load & ~w_mem_empty;
  end

  // Storage array, no reset needed: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_mem_wr) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
  end

  // Pointers, occupancy and the registered stream head.
  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
    end else begin
      if (w_mem_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_mem_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
      if (w_load) begin
        if (w_mem_rd) begin
          r_tdata  <= r_mem[r_rd_ptr];
          r_tvalid <= 1'b1;
        end else if (w_push) begin
          r_tdata  <= w_wr_data;
          r_tvalid <= 1'b1;
        end else begin
          r_tvalid <= 1'b0;
        end
      end
    end
  end

  // Saturating drop counter and sticky overflow flag.
  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_dropped  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_drop && (r_dropped != {DROP_W{1'b1}})) begin
        r_dropped <= r_dropped + DROP_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef TRACE_OVERFLOW_MARKER_EN
  // One pending marker covers any number of drops before it is inserted.
  always_ff @(posedge clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_mark_pend <= 1'b0;
    end else if (w_drop) begin
      r_mark_pend <= 1'b1;
    end else if (w_mark_ins) begin
      r_mark_pend <= 1'b0;
    end
  end
`endif

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;
  assign fifo_level    = r_level;
  assign dropped_count = r_dropped;
  assign overflow      = r_overflow;

endmodule

// File: doc/event_trace_packer.md
Name: event_trace_packer

Overview:
- Consumes the per-signal rising/falling edge pulses produced by the edge-detect stage, for NUM_CH monitored accelerator signals.
- Stamps each event cycle with a free-running timestamp and buffers the words in a FIFO.
- Presents the words as an AXI4-Stream master toward the trace offload/DMA path.
- Sits directly downstream of the edge-pulse stage in the trace monitor.

Parameters:
- NUM_CH, 4, number of monitored channels (1..16).
- TS_W, 32, timestamp counter width (16..48).
- FIFO_DEPTH, 16, event FIFO depth in words; power of two, 4..256.
- DROP_W, 16, width of the dropped-event counter.

Ports:
- clk  in  1  sampling/trace clock, same clock as the edge-pulse stage.
- resetn  in  1  asynchronous, active-low reset.
- enable  in  1  1 = capture events; 0 = ignore pulses (timestamp keeps running).
- rise_pulse  in  NUM_CH  per-channel one-cycle rising-edge pulses.
- fall_pulse  in  NUM_CH  per-channel one-cycle falling-edge pulses.
- m_axis_tdata  out  2*NUM_CH+TS_W  {rise_vec, fall_vec, timestamp}, MSB to LSB.
- m_axis_tvalid  out  1  word available.
- m_axis_tready  in  1  downstream accepts.
- fifo_level  out  clog2(FIFO_DEPTH)+1  current occupancy.
- dropped_count  out  DROP_W  saturating count of event words lost to a full FIFO.
- overflow  out  1  sticky; set on first drop, cleared only by reset.

Behaviour:
- Reset (async assert, sync deassert internally):
  - Timestamp = 0; FIFO empty.
  - tvalid = 0, tdata = 0, fifo_level = 0, dropped_count = 0, overflow = 0.
  - Asserting resetn mid-transfer discards all buffered words; tvalid drops immediately.
- Timestamp:
  - Increments by 1 every clk after reset.
  - Wraps from 2^TS_W-1 to 0 silently; no wrap marker.
- Event cycle:
  - Any cycle where enable=1 and (|rise_pulse | |fall_pulse).
  - One word per event cycle: all simultaneous channel pulses are packed into a single word, with the timestamp value held at that clock edge (pre-increment).
- Latency:
  - Pulses and timestamp are registered at edge E; the FIFO write happens at edge E+1.
  - With the FIFO empty, tvalid=1 after edge E+1, giving 2-cycle pulse-to-tvalid latency.
- Sustained throughput: one event word per cycle in, one word per cycle out.
- AXI-Stream rules:
  - Once tvalid=1, tdata is held stable until the tvalid&tready handshake.
  - tvalid never deasserts without a handshake, except on reset.
  - The next word is presented on the cycle after a handshake; there are no bubbles while the FIFO is non-empty.
- FIFO full:
  - A write is accepted when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
  - Otherwise the word is dropped: dropped_count += 1 (saturates at all-ones) and overflow is set.
- Empty FIFO: tvalid=0 and tdata keeps its last value.
- Consistency rule: fifo_level = words written − words popped, updated on the same edge as the write/pop.
- enable deasserted: in-flight words still drain; pulses are ignored with no drop counting.
- rise and fall asserted for the same channel in the same cycle is impossible upstream; that encoding is reserved.

Optional Feature:
- Macro: TRACE_OVERFLOW_MARKER_EN.
- Defined:
  - After any drop, a pending-marker flag is set.
  - In the first subsequent cycle with no incoming event word and FIFO not full, a marker word is written: rise_vec = all ones, fall_vec = all ones, timestamp = current value.
  - The pending flag clears on that write; multiple drops before insertion produce one marker.
  - dropped_count and overflow behave unchanged.
- Undefined: no marker words are generated; the reserved encoding never appears on the output.

Test Plan:
- Single event: NUM_CH=4; after reset, rise_pulse=4'b0010 at the edge where ts=10, tready=1 -> tvalid high 2 cycles later; tdata={4'b0010, 4'b0000, 32'd10}; one handshake; fifo_level returns to 0.
- Simultaneous pulses: rise=4'b0001 and fall=4'b1000 in the same cycle -> exactly one word {0001, 1000, ts}; no second word.
- Backpressure and full: tready=0, 20 consecutive event cycles with FIFO_DEPTH=16 -> fifo_level=16, dropped_count=4, overflow=1. Then tready=1 -> 16 words out, in order, with timestamps consecutive; tvalid/tdata stable throughout the stall.
- Full with simultaneous pop: FIFO full, tready=1 while one event arrives -> write accepted, fifo_level stays 16, dropped_count unchanged.
- Reset mid-operation: FIFO holding 5 words, tvalid=1; pulse resetn low one cycle -> tvalid=0 immediately; fifo_level=0, dropped_count=0. Next event carries ts counted from 0.
- With TRACE_OVERFLOW_MARKER_EN: force 3 drops, then release tready with an idle input -> exactly one marker {1111, 1111, ts} after the buffered words. Without the macro -> no marker appears.
